// File: rtl/dualport_shared_memory.sv
// True dual-port shared RAM with two Avalon-MM slave ports: read latency 1 or 2, s1-wins write-collision stall.
// Optional collision_count output is built when DUALPORT_SHARED_MEMORY_COLLISION_CNT_EN is defined.
module dualport_shared_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 13,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "dualport_shared_memory.hex"
) (
`ifdef DUALPORT_SHARED_MEMORY_COLLISION_CNT_EN
  output logic [15:0]             collision_count,
`endif
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("dualport_shared_memory: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("dualport_shared_memory: DATA_WIDTH must be a multiple of 8");
  end
  // The memory image named by INIT_FILE is applied by the device configuration flow, not by logic here.
  if (INIT_FILE == "") begin : g_no_image
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] ram1_q, ram2_q;
  logic [1:0]            vld1_q, vld1_d;
  logic                  ram_en, coll_stall;
  logic                  s1_acc_wr, s1_acc_rd, s2_acc_wr, s2_acc_rd;

  assign ram_en     = ~reset & ~reset_req;
  assign coll_stall = s1_chipselect & s1_write & s2_chipselect & s2_write &
                      (s1_address == s2_address);

  assign s1_waitrequest = reset | reset_req;
  assign s2_waitrequest = reset | reset_req | coll_stall;

  // Write wins over a simultaneous read on the same port.
  assign s1_acc_wr = s1_chipselect & s1_write & ~s1_waitrequest;
  assign s1_acc_rd = s1_chipselect & s1_read & ~s1_write & ~s1_waitrequest;
  assign s2_acc_wr = s2_chipselect & s2_write & ~s2_waitrequest;
  assign s2_acc_rd = s2_chipselect & s2_read & ~s2_write & ~s2_waitrequest;

  // Reads sample the array before this edge's writes land, so a cross-port reader sees old data.
  always_ff @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (s2_acc_wr && s2_byteenable[b]) mem_q[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
        if (s1_acc_wr && s1_byteenable[b]) mem_q[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
      end
      if (s1_acc_rd) ram1_q <= mem_q[s1_address];
      if (s2_acc_rd) ram2_q <= mem_q[s2_address];
    end
  end

  assign vld1_d = {s2_acc_rd, s1_acc_rd};

  always_ff @(posedge clk) begin
    if (reset) vld1_q <= '0;
    else       vld1_q <= vld1_d;
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0]            vld2_q;
    logic [DATA_WIDTH-1:0] rd1_q, rd2_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        vld2_q <= '0;
        rd1_q  <= '0;
        rd2_q  <= '0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q[0]) rd1_q <= ram1_q;
        if (vld1_q[1]) rd2_q <= ram2_q;
      end
    end

    assign s1_readdata      = rd1_q;
    assign s2_readdata      = rd2_q;
    assign s1_readdatavalid = vld2_q[0];
    assign s2_readdatavalid = vld2_q[1];
  end else begin : g_lat1
    assign s1_readdata      = ram1_q;
    assign s2_readdata      = ram2_q;
    assign s1_readdatavalid = vld1_q[0];
    assign s2_readdatavalid = vld1_q[1];
  end

`ifdef DUALPORT_SHARED_MEMORY_COLLISION_CNT_EN
  logic [15:0] coll_cnt_q, coll_cnt_d;

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll_stall && ram_en && coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) coll_cnt_q <= '0;
    else       coll_cnt_q <= coll_cnt_d;
  end

  assign collision_count = coll_cnt_q;
`endif

endmodule

// File: tb/tb_dualport_shared_memory.sv
// Directed bench: one instance at READ_LATENCY 1 (a_*) and one at 2 (b_*) share all inputs.
module tb_dualport_shared_memory;

  logic        clk = 1'b0;
  logic        reset, reset_req;
  logic [12:0] s1_address, s2_address;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata;
  logic        a_s1_rvld, a_s2_rvld, b_s1_rvld, b_s2_rvld;
  logic        a_s1_wait, a_s2_wait, b_s1_wait, b_s2_wait;
`ifdef DUALPORT_SHARED_MEMORY_COLLISION_CNT_EN
  logic [15:0] a_cc, b_cc;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dualport_shared_memory #(.READ_LATENCY(1)) u_lat1 (
`ifdef DUALPORT_SHARED_MEMORY_COLLISION_CNT_EN
    .collision_count(a_cc),
`endif
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(a_s1_rdata), .s1_readdatavalid(a_s1_rvld), .s1_waitrequest(a_s1_wait),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(a_s2_rdata), .s2_readdatavalid(a_s2_rvld), .s2_waitrequest(a_s2_wait)
  );

  dualport_shared_memory #(.READ_LATENCY(2)) u_lat2 (
`ifdef DUALPORT_SHARED_MEMORY_COLLISION_CNT_EN
    .collision_count(b_cc),
`endif
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(b_s1_rdata), .s1_readdatavalid(b_s1_rvld), .s1_waitrequest(b_s1_wait),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(b_s2_rdata), .s2_readdatavalid(b_s2_rvld), .s2_waitrequest(b_s2_wait)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  task automatic wr1(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    s1_chipselect = 1; s1_write = 1; s1_read = 0; s1_address = a; s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic wr2(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    s2_chipselect = 1; s2_write = 1; s2_read = 0; s2_address = a; s2_writedata = d; s2_byteenable = be;
  endtask

  task automatic rd1(input logic [12:0] a);
    s1_chipselect = 1; s1_read = 1; s1_write = 0; s1_address = a;
  endtask

  task automatic rd2(input logic [12:0] a);
    s2_chipselect = 1; s2_read = 1; s2_write = 0; s2_address = a;
  endtask

  logic [12:0] burst_addr [4];
  logic [31:0] burst_data [4];

  initial begin
    reset = 1; reset_req = 0;
    s1_address = '0; s2_address = '0; s1_byteenable = '0; s2_byteenable = '0;
    s1_writedata = '0; s2_writedata = '0;
    idle();
    repeat (3) step();

    chk("rst_s1_wait", {31'd0, a_s1_wait}, 32'd1);
    chk("rst_s2_wait", {31'd0, a_s2_wait}, 32'd1);
    chk("rst_a_vld",   {30'd0, a_s1_rvld, a_s2_rvld}, 32'd0);
    chk("rst_b_vld",   {30'd0, b_s1_rvld, b_s2_rvld}, 32'd0);
    chk("rst_b_s1_data", b_s1_rdata, 32'd0);
    chk("rst_b_s2_data", b_s2_rdata, 32'd0);

    reset = 0;
    #1;
    chk("run_s1_wait", {31'd0, a_s1_wait}, 32'd0);
    chk("run_s2_wait", {31'd0, b_s2_wait}, 32'd0);

    // Write then read, both latencies.
    wr1(13'd5, 32'hDEADBEEF, 4'hF);
    step();
    rd1(13'd5);
    step();
    chk("l1_vld",  {31'd0, a_s1_rvld}, 32'd1);
    chk("l1_data", a_s1_rdata, 32'hDEADBEEF);
    chk("l2_vld_early", {31'd0, b_s1_rvld}, 32'd0);
    idle();
    step();
    chk("l1_vld_once", {31'd0, a_s1_rvld}, 32'd0);
    chk("l2_vld",  {31'd0, b_s1_rvld}, 32'd1);
    chk("l2_data", b_s1_rdata, 32'hDEADBEEF);
    step();
    chk("l2_vld_once", {31'd0, b_s1_rvld}, 32'd0);

    // Byte enables.
    wr1(13'd9, 32'h11223344, 4'hF);
    step();
    idle();
    wr2(13'd9, 32'hAABBCCDD, 4'b0101);
    step();
    idle();
    rd1(13'd9);
    step();
    idle();
    chk("be_l1", a_s1_rdata, 32'h11BB33DD);
    step();
    chk("be_l2", b_s1_rdata, 32'h11BB33DD);

    // Cross-port read during write returns old data.
    wr1(13'd3, 32'h0, 4'hF);
    step();
    wr1(13'd3, 32'h5, 4'hF);
    rd2(13'd3);
    step();
    chk("rdw_vld", {31'd0, a_s2_rvld}, 32'd1);
    chk("rdw_old", a_s2_rdata, 32'h0);
    s1_chipselect = 0; s1_write = 0;
    step();
    chk("rdw_new", a_s2_rdata, 32'h5);
    chk("rdw_old_l2", b_s2_rdata, 32'h0);
    idle();
    step();
    chk("rdw_new_l2", b_s2_rdata, 32'h5);

    // Same-word write collision: s1 wins, s2 stalls one cycle and lands afterwards.
    wr1(13'd7, 32'hA, 4'hF);
    wr2(13'd7, 32'hB, 4'hF);
    #1;
    chk("coll_s2_wait", {31'd0, a_s2_wait}, 32'd1);
    chk("coll_s1_wait", {31'd0, a_s1_wait}, 32'd0);
    step();
    s1_chipselect = 0; s1_write = 0;
    #1;
    chk("coll_s2_release", {31'd0, a_s2_wait}, 32'd0);
    step();
    idle();
    rd1(13'd7);
    step();
    idle();
    chk("coll_final", a_s1_rdata, 32'hB);
`ifdef DUALPORT_SHARED_MEMORY_COLLISION_CNT_EN
    chk("coll_count", {16'd0, a_cc}, 32'd1);
`endif

    // Different addresses: no stall, both land.
    wr1(13'd20, 32'h1234_0020, 4'hF);
    wr2(13'd21, 32'h1234_0021, 4'hF);
    #1;
    chk("nocoll_s2_wait", {31'd0, a_s2_wait}, 32'd0);
    step();
    rd1(13'd20);
    rd2(13'd21);
    step();
    idle();
    chk("nocoll_s1", a_s1_rdata, 32'h1234_0020);
    chk("nocoll_s2", a_s2_rdata, 32'h1234_0021);
    step();

    // Back-to-back reads, then reset_req: in-flight reads drain, no new accepts.
    burst_addr[0] = 13'd5;  burst_data[0] = 32'hDEADBEEF;
    burst_addr[1] = 13'd9;  burst_data[1] = 32'h11BB33DD;
    burst_addr[2] = 13'd3;  burst_data[2] = 32'h5;
    burst_addr[3] = 13'd7;  burst_data[3] = 32'hB;
    for (int i = 0; i < 4; i++) begin
      rd1(burst_addr[i]);
      step();
      chk("burst_l1_vld",  {31'd0, a_s1_rvld}, 32'd1);
      chk("burst_l1_data", a_s1_rdata, burst_data[i]);
      if (i > 0) begin
        chk("burst_l2_vld",  {31'd0, b_s1_rvld}, 32'd1);
        chk("burst_l2_data", b_s1_rdata, burst_data[i-1]);
      end
    end
    reset_req = 1;
    wr1(13'd5, 32'h0, 4'hF);
    rd2(13'd9);
    #1;
    chk("rreq_s1_wait", {31'd0, a_s1_wait}, 32'd1);
    chk("rreq_s2_wait", {31'd0, a_s2_wait}, 32'd1);
    step();
    chk("rreq_l1_noacc", {30'd0, a_s1_rvld, a_s2_rvld}, 32'd0);
    chk("rreq_l2_drain_vld", {31'd0, b_s1_rvld}, 32'd1);
    chk("rreq_l2_drain_data", b_s1_rdata, burst_data[3]);
    step();
    chk("rreq_l2_noacc", {30'd0, b_s1_rvld, b_s2_rvld}, 32'd0);
    reset_req = 0;
    idle();
    rd1(13'd5);
    step();
    idle();
    chk("rreq_no_write", a_s1_rdata, 32'hDEADBEEF);
    step();
    step();

    // Reset one cycle after a latency-2 read accept discards it.
    rd1(13'd9);
    step();
    idle();
    reset = 1;
    step();
    chk("midrst_l2_vld", {31'd0, b_s1_rvld}, 32'd0);
    chk("midrst_l1_vld", {31'd0, a_s1_rvld}, 32'd0);
    chk("midrst_l2_data", b_s1_rdata, 32'd0);
    step();
    chk("midrst_l2_vld_late", {31'd0, b_s1_rvld}, 32'd0);
`ifdef DUALPORT_SHARED_MEMORY_COLLISION_CNT_EN
    chk("midrst_count", {16'd0, b_cc}, 32'd0);
`endif
    reset = 0;
    rd1(13'd9);
    step();
    idle();
    chk("rst_keeps_ram", a_s1_rdata, 32'h11BB33DD);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dualport_shared_memory.md
Name: dualport_shared_memory

Overview:
- Parametrised true dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2) on one clock.
- Intended as a shared mailbox/data buffer between two cores in the multi-core platform; successor to the fixed 32x8192 single-port on-chip memory.
- Adds configurable width/depth, read latency 1 or 2 with readdatavalid, same-word write-collision arbitration with waitrequest stall, and clock-enable gating from reset_req.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 13, word address bits; depth = 2**ADDR_WIDTH.
- READ_LATENCY, 1, 1 = unregistered RAM output, 2 = extra output register; other values are illegal (elaboration error).
- INIT_FILE, "dualport_shared_memory.hex", memory initialisation file; contents are loaded at configuration only.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- reset_req, input, 1, early reset request; gates all RAM access.
- s1_address, input, ADDR_WIDTH, port 1 word address.
- s1_byteenable, input, DATA_WIDTH/8, port 1 byte lanes.
- s1_chipselect, input, 1, port 1 select.
- s1_read, input, 1, port 1 read request.
- s1_write, input, 1, port 1 write request.
- s1_writedata, input, DATA_WIDTH, port 1 write data.
- s1_readdata, output, DATA_WIDTH, port 1 read data.
- s1_readdatavalid, output, 1, port 1 read data valid.
- s1_waitrequest, output, 1, port 1 stall.
- s2_*, same seven inputs and three outputs as s1, for port 2.

Behaviour:
- The clock is clk. Reset is synchronous and active-high on reset, sampled on the rising clk edge.
- Reset:
  - readdatavalid pipelines cleared; s*_readdatavalid = 0, s*_readdata = 0 (READ_LATENCY 2 register).
  - s*_waitrequest = 1 while reset is high.
  - RAM contents are not altered.
- A request on port N is accepted when chipselect & (read | write) & ~waitrequest is true at a rising edge.
- If read and write are both high, the write takes effect and the read is ignored.
- Write: bytes with byteenable[i] = 1 are updated at the accept edge. Disabled lanes are unchanged.
- Read:
  - readdata is valid with readdatavalid = 1 exactly READ_LATENCY cycles after the accept edge, for one cycle.
  - Back-to-back reads are accepted every cycle and are fully pipelined.
- Read-during-write:
  - Same-port: read-before-write; cannot occur, since read is ignored when write is high.
  - Cross-port same word, same cycle: the reader returns the OLD data.
- Write collision: both ports write the same address in the same cycle.
  - s1 wins and is accepted.
  - s2_waitrequest = 1 for exactly that cycle. s2 holds its request, and it is accepted the next cycle, so s2's data is the final value.
  - Different addresses: both accepted, no stall.
- waitrequest is combinational from inputs, plus reset and reset_req:
  - waitrequest = reset | reset_req | (port-2 collision term, s2 only).
- reset_req high:
  - No accepts on either port and RAM clock enable deasserted.
  - In-flight readdatavalid pipelines still advance and drain, so reads already accepted complete.
- Reset mid-read: a pending readdatavalid is discarded (never asserted).
- Address wrap: none; the address is exactly ADDR_WIDTH bits and covers the full depth.

Optional Feature:
- Macro: DUALPORT_SHARED_MEMORY_COLLISION_CNT_EN.
- When defined:
  - Adds output collision_count [15:0].
  - Increments by 1 on each cycle where a same-word write collision stalls s2.
  - Saturates at 16'hFFFF; cleared to 0 by reset.
- When not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Write/read, latency 1: s1 writes 32'hDEADBEEF to addr 5, then reads addr 5 → s1_readdata = 32'hDEADBEEF with s1_readdatavalid high exactly 1 cycle after the read accept; repeat with READ_LATENCY = 2 → valid at 2 cycles.
- Byte enables: write 32'h11223344 to addr 9, then s2 writes 32'hAABBCCDD with byteenable 4'b0101 → read returns 32'h11BB33DD.
- Cross-port read-during-write: addr 3 holds 32'h0; in the same cycle s1 writes 32'h5 to addr 3 and s2 reads addr 3 → s2 gets 32'h0; the next s2 read gets 32'h5.
- Write collision: s1 writes 32'hA and s2 writes 32'hB to addr 7 in the same cycle → s2_waitrequest high for 1 cycle, s2 accepted the next cycle, addr 7 reads 32'hB; collision_count = 1 when the macro is defined.
- reset_req and reset: issue 4 back-to-back reads, then raise reset_req → all 4 readdatavalid pulses still arrive, no new accepts, waitrequest = 1; a read accepted one cycle before reset with READ_LATENCY 2 → no readdatavalid, all outputs 0 after reset.
